// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Width needed to hold a pattern length from 0 up to max_len inclusive.
  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = calc_len_w(DEF_MAX_LEN);

endpackage

// File: rtl/seq_det_hist.sv
// Bit history shift register with a saturating count of valid bits held.
module seq_det_hist #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               shift,
  input  logic               fill_clr,
  input  logic               x,
  output logic [MAX_LEN-1:0] hist_nxt,
  output logic [LEN_W-1:0]   fill_nxt
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_reg;
  logic [LEN_W-1:0]   fill_reg;

  // Look-ahead values let the caller compare against the bit being shifted in now.
  assign hist_nxt = shift ? {hist_reg[MAX_LEN-2:0], x} : hist_reg;
  assign fill_nxt = !shift                ? fill_reg :
                    (fill_reg == FILL_MAX) ? FILL_MAX : fill_reg + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (clr) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else begin
      hist_reg <= hist_nxt;
      fill_reg <= fill_clr ? '0 : fill_nxt;
    end
  end

endmodule

// File: rtl/seq_det_param.sv
// Runtime-programmable serial bit-pattern detector with registered match pulse.
// Optional saturating match counter is built when SEQ_DET_CNT_EN is defined.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = calc_len_w(MAX_LEN),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               x_valid,
  input  logic               x,
  output logic               z,
  output logic               armed,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_count
);

  state_t             state_reg, state_next;
  logic [MAX_LEN-1:0] pat_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               ovl_reg;
  logic               z_reg;
  logic               err_reg;

  logic               len_ok;
  logic               shift;
  logic               hit;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] eq;
  logic [LEN_W-1:0]   fill_nxt;

  assign len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  // A config load takes priority over the data bit presented in the same cycle.
  assign shift  = (state_reg == RUN) && x_valid && !cfg_load;

  seq_det_hist #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cfg_load),
    .shift   (shift),
    .fill_clr(hit && !ovl_reg),
    .x       (x),
    .hist_nxt(hist_nxt),
    .fill_nxt(fill_nxt)
  );

  // Bits at or above the programmed length always compare equal.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
      assign eq[gi] = (LEN_W'(gi) >= len_reg) || (hist_nxt[gi] == pat_reg[gi]);
    end
  endgenerate

  assign hit = shift && (fill_nxt >= len_reg) && (&eq);

  always_comb begin
    state_next = state_reg;
    if (cfg_load) begin
      state_next = len_ok ? RUN : UNCFG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= UNCFG;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_reg <= '0;
      len_reg <= '0;
      ovl_reg <= 1'b0;
      z_reg   <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      z_reg <= hit;
      if (cfg_load) begin
        pat_reg <= cfg_pattern;
        len_reg <= cfg_len;
        ovl_reg <= cfg_overlap;
        err_reg <= !len_ok;
      end
    end
  end

  assign z       = z_reg;
  assign armed   = (state_reg == RUN);
  assign cfg_err = err_reg;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (cfg_load) begin
      cnt_reg <= '0;
    end else if (hit && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign match_count = cnt_reg;
`else
  assign match_count = '0;
`endif

endmodule
